vga_sync_monitor: RTL

- Receive-side counterpart to the VGA output of vga_top. Samples the h, v, r, g, b lines and recovers the pixel clock phase, x/y coordinates and pixel colour.
- Checks hsync and vsync timing against 640x480@60 parameters and reports lock and timing errors.
- Used in simulation and on-board loopback to check the game's video output without a monitor.

---
 rtl/vga_sync_monitor.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA checker: samples h/v/rgb, recovers pixel phase and x/y,
// checks sync timing against the configured mode and reports lock and errors.
module vga_sync_monitor #(
    parameter int CLKS_PER_PIX = 4,
    parameter int H_VISIBLE    = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       h,
    input  logic       v,
    input  logic       r,
    input  logic       g,
    input  logic       b,
    output logic       pix_valid,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [2:0] rgb,
    output logic       locked,
    output logic       h_err,
    output logic       v_err,
    output logic       frame_done,
    output logic [7:0] err_cnt
);

    localparam int P_W     = (CLKS_PER_PIX > 1) ? $clog2(CLKS_PER_PIX) : 1;
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int H_END   = H_START + H_VISIBLE;
    localparam int V_START = V_SYNC + V_BP;
    localparam int V_END   = V_START + V_VISIBLE;

    localparam logic [P_W-1:0] P_ONE  = P_W'(1);
    localparam logic [P_W-1:0] P_MID  = P_W'(CLKS_PER_PIX / 2);
    localparam logic [P_W-1:0] P_LAST = P_W'(CLKS_PER_PIX - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    logic           h_s, v_s, h_d, v_d;
    logic [2:0]     rgb_s;
    logic           hfall, hrise, vfall, vrise;
    logic [P_W-1:0] p;
    logic [10:0]    h_cnt;
    logic [9:0]     v_cnt;
    logic [10:0]    eff_lines;
    logic           h_armed;
    state_t         state, state_n;
    logic           err_flag, err_flag_n;
    logic           h_err_c, v_err_c, any_err;
    logic           capture, done_c;
    logic [8:0]     err_sum;

    // Input registration plus one extra delay on the sync lines for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge value of its neighbours, independent of block order.
        if (!rst) begin
            h_s   <= 1'b0;
            v_s   <= 1'b0;
            h_d   <= 1'b0;
            v_d   <= 1'b0;
            rgb_s <= 3'b000;
        end else begin
            h_s   <= h;
            v_s   <= v;
            h_d   <= h_s;
            v_d   <= v_s;
            rgb_s <= {r, g, b};
        end
    end

    assign hfall = h_d & ~h_s;
    assign hrise = ~h_d & h_s;
    assign vfall = v_d & ~v_s;
    assign vrise = ~v_d & v_s;

    // The hfall cycle is phase 0 of pixel 0, so the next cycle starts at phase 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p     <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (hfall) begin
                p     <= P_ONE;
                h_cnt <= '0;
            end else begin
                p <= p + 1'b1;
                if (p == P_LAST && h_cnt != '1)
                    h_cnt <= h_cnt + 1'b1;
            end
            if (vfall)
                v_cnt <= '0;
            else if (hfall && v_cnt != '1)
                v_cnt <= v_cnt + 1'b1;
        end
    end

    assign eff_lines = {1'b0, v_cnt} + {10'd0, hfall};

    // Horizontal checks need one full line measured since leaving SEARCH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            h_armed <= 1'b0;
        else if (state == SEARCH)
            h_armed <= 1'b0;
        else if (hfall)
            h_armed <= 1'b1;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can
        // leave it unassigned and infer a latch.
        h_err_c = 1'b0;
        v_err_c = 1'b0;
        if (state != SEARCH) begin
            if (h_armed) begin
                if (hfall && !(h_cnt == 11'(H_TOTAL) && p == '0))
                    h_err_c = 1'b1;
                if (hrise && !(h_cnt == 11'(H_SYNC) && p == '0))
                    h_err_c = 1'b1;
            end
            if (vfall && eff_lines != 11'(V_TOTAL))
                v_err_c = 1'b1;
            if (vrise && eff_lines != 11'(V_SYNC))
                v_err_c = 1'b1;
        end
        any_err = h_err_c | v_err_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= SEARCH;
            err_flag <= 1'b0;
        end else begin
            state    <= state_n;
            err_flag <= err_flag_n;
        end
    end

    always_comb begin
        state_n    = state;
        err_flag_n = err_flag;
        unique case (state)
            SEARCH: begin
                if (vfall) begin
                    state_n    = MEASURE;
                    err_flag_n = 1'b0;
                end
            end
            MEASURE: begin
                // A frame boundary always starts a fresh measurement.
                if (vfall) begin
                    if (!err_flag && !any_err)
                        state_n = LOCKED;
                    err_flag_n = 1'b0;
                end else if (any_err) begin
                    err_flag_n = 1'b1;
                end
            end
            LOCKED: begin
                if (any_err) begin
                    state_n    = MEASURE;
                    err_flag_n = 1'b0;
                end
            end
            default: begin
                state_n    = SEARCH;
                err_flag_n = 1'b0;
            end
        endcase
    end

    always_comb begin
        locked  = (state == LOCKED);
        done_c  = (state == LOCKED) && vfall && !v_err_c;
        capture = (state == LOCKED) && (p == P_MID)
                  && (h_cnt >= 11'(H_START)) && (h_cnt < 11'(H_END))
                  && (v_cnt >= 10'(V_START)) && (v_cnt < 10'(V_END));
    end

    assign err_sum = {1'b0, err_cnt} + {8'd0, h_err_c} + {8'd0, v_err_c};

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the captured pixel registers are reset as well, so every output
        // reads zero while reset is held rather than showing stale data.
        if (!rst) begin
            pix_valid  <= 1'b0;
            x          <= '0;
            y          <= '0;
            rgb        <= '0;
            h_err      <= 1'b0;
            v_err      <= 1'b0;
            frame_done <= 1'b0;
            err_cnt    <= '0;
        end else begin
            pix_valid  <= capture;
            if (capture) begin
                x   <= 10'(h_cnt - 11'(H_START));
                y   <= v_cnt - 10'(V_START);
                rgb <= rgb_s;
            end
            h_err      <= h_err_c;
            v_err      <= v_err_c;
            frame_done <= done_c;
            err_cnt    <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

endmodule
